// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI slave
// Purpose: state encoding and SPI mode constants used by spi_slave and spi_sync_edge.
// Ports: none (package).
package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
  } spi_slave_state_t;

  // Mode 0: SCK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchroniser with rise/fall pulse outputs
// Purpose: bring one asynchronous pin into the clk domain and flag its edges.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   d_i       : asynchronous input pin
//   level_o   : synchronised level (last synchroniser flop)
//   rise_o    : 1-cycle pulse, synchronised level went 0->1
//   fall_o    : 1-cycle pulse, synchronised level went 1->0
import spi_pkg::*;

module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, MSB-first, oversampled in the clk domain
// Purpose: deserialise MOSI into words with an rx pulse, serialise staged tx words on MISO.
// Optional feature macro: SPI_SLAVE_MISO_OE_EN (adds spi_miso_oe, MISO holds when deselected).
// Ports:
//   clk, rst                 : system clock, asynchronous active-high reset
//   spi_sck/cs_n/mosi        : asynchronous SPI pins from the master
//   spi_miso                 : slave-out data
//   tx_data/valid/ready      : local tx handshake into a one-word staging register
//   rx_data/rx_valid         : received word and its 1-cycle update pulse
//   tx_underrun              : pulse, word load found staging empty (FILL_WORD sent)
//   frame_err                : pulse, CS_N rose mid-word
//   spi_miso_oe              : (macro only) synchronised chip-select active
import spi_pkg::*;

module spi_slave #(
  parameter int                     DATA_LENGTH = 8,
  parameter int                     SYNC_STAGES = 2,
  parameter logic [DATA_LENGTH-1:0] FILL_WORD   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sck,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic [DATA_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [DATA_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   tx_underrun,
  output logic                   frame_err
`ifdef SPI_SLAVE_MISO_OE_EN
  ,
  output logic                   spi_miso_oe
`endif
);

  localparam int CW = $clog2(DATA_LENGTH + 1);

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_sck_level;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sck (
    .clk     (clk),
    .rst     (rst),
    .d_i     (spi_sck),
    .level_o (sck_level),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  // CS_N resets to its idle (high) level so reset release never looks like a select.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk     (clk),
    .rst     (rst),
    .d_i     (spi_cs_n),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  assign unused_sck_level = sck_level;

  // MOSI gets the same depth as the SCK level so the sampled bit lines up with sck_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   mosi_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end

  assign mosi_sync = mosi_sync_q[SYNC_STAGES-1];

  // Staging register (one word deep)
  logic [DATA_LENGTH-1:0] stage_q;
  logic                   stage_full_q;
  logic                   load_d;

  // FSM registers
  spi_slave_state_t       state_q;
  logic [CW-1:0]          bit_cnt_q;
  logic [DATA_LENGTH-1:0] shift_rx_q;
  logic [DATA_LENGTH-1:0] shift_tx_q;
  logic                   reload_pend_q;
  logic                   miso_q;
  logic [DATA_LENGTH-1:0] rx_data_q;
  logic                   rx_valid_q;
  logic                   tx_underrun_q;
  logic                   frame_err_q;

  logic [DATA_LENGTH-1:0] load_word_d;
  logic [DATA_LENGTH-1:0] rx_word_d;
  logic                   last_bit;
  logic                   sck_rise_sel;
  logic                   sck_fall_sel;

  assign load_word_d  = stage_full_q ? stage_q : FILL_WORD;
  assign rx_word_d    = {shift_rx_q[DATA_LENGTH-2:0], mosi_sync};
  assign last_bit     = (bit_cnt_q == CW'(DATA_LENGTH - 1));
  assign sck_rise_sel = sck_rise & ~cs_level;
  assign sck_fall_sel = sck_fall & ~cs_level;

  // A word is pulled from staging at select, and at the end of every full word.
  always_comb begin
    load_d = 1'b0;
    if (state_q == S_IDLE) load_d = cs_fall;
    else                   load_d = ~cs_rise & sck_rise_sel & last_bit;
  end

  // A load and an accept in the same cycle: the load sees the old (empty) staging,
  // then the new word lands in staging because tx_ready was high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q      <= '0;
      stage_full_q <= 1'b0;
    end else if (tx_valid && !stage_full_q) begin
      stage_q      <= tx_data;
      stage_full_q <= 1'b1;
    end else if (load_d) begin
      stage_full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_rx_q    <= '0;
      shift_tx_q    <= '0;
      reload_pend_q <= 1'b0;
      miso_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= load_d & ~stage_full_q;
      frame_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
`ifndef SPI_SLAVE_MISO_OE_EN
          miso_q <= 1'b0;
`endif
          if (cs_fall) begin
            shift_tx_q    <= load_word_d;
            miso_q        <= load_word_d[DATA_LENGTH-1];
            reload_pend_q <= 1'b0;
            bit_cnt_q     <= '0;
            state_q       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            // Deselect wins over a coincident SCK edge; a partial word is dropped.
            state_q     <= S_IDLE;
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
`ifndef SPI_SLAVE_MISO_OE_EN
            miso_q      <= 1'b0;
`endif
          end else if (sck_rise_sel) begin
            shift_rx_q <= rx_word_d;
            if (last_bit) begin
              rx_data_q     <= rx_word_d;
              rx_valid_q    <= 1'b1;
              bit_cnt_q     <= '0;
              shift_tx_q    <= load_word_d;
              reload_pend_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CW'(1);
            end
          end else if (sck_fall_sel) begin
            // After a reload the next falling edge presents the new MSB unshifted.
            if (reload_pend_q) begin
              miso_q        <= shift_tx_q[DATA_LENGTH-1];
              reload_pend_q <= 1'b0;
            end else begin
              miso_q     <= shift_tx_q[DATA_LENGTH-2];
              shift_tx_q <= {shift_tx_q[DATA_LENGTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign tx_ready    = ~stage_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;
  assign frame_err   = frame_err_q;
`ifdef SPI_SLAVE_MISO_OE_EN
  assign spi_miso_oe = ~cs_level;
`endif

endmodule
